// File: rtl/alu_mdu_seq.sv
// Execute-stage RV32I ALU with an iterative RV32M multiply/divide unit, registered result and start/done handshake.
// Define ALU_MDU_FLUSH_EN to add a flush input that aborts an in-flight multiply/divide.
module alu_mdu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
`ifdef ALU_MDU_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, done_q, done_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [1:0]          mop_q, mop_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                flush_c;

`ifdef ALU_MDU_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Base-group result; every unlisted code passes A through.
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  assign shamt = b[SHW-1:0];
  always_comb begin
    case (op)
      5'd0:    alu_res = a + b;
      5'd1:    alu_res = a - b;
      5'd2:    alu_res = a ^ b;
      5'd3:    alu_res = a | b;
      5'd4:    alu_res = a & b;
      5'd5:    alu_res = a << shamt;
      5'd6:    alu_res = a >> shamt;
      5'd7:    alu_res = $signed(a) >>> shamt;
      5'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'd9:    alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = a;
    endcase
  end

  // Operand capture: op[2:0] within the M group selects signedness of each operand.
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  assign a_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign b_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;

  // Shift-add step: acc = {partial_hi, multiplier_lo}, multiplicand in opnd_q.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

  // Restoring step: acc = {remainder, dividend/quotient}, divisor in opnd_q.
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_sel;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[XLEN];
  assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ok};
  assign div_sel   = mop_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];

  logic div_by_zero, div_ovf;
  assign div_by_zero = (b == '0);
  assign div_ovf     = !op[0] && (a == MIN_NEG) && (&b);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush_c) begin
          if (!op[4] || op[3]) begin
            result_d = alu_res;
            done_d   = 1'b1;
          end else if (op[2] && (div_by_zero || div_ovf)) begin
            if (div_by_zero) result_d = op[1] ? a : '1;
            else             result_d = op[1] ? '0 : a;
            done_d = 1'b1;
          end else begin
            mop_d   = op[1:0];
            cnt_d   = '0;
            neg_d   = (op[2:0] == 3'd2 || op[2:0] == 3'd6) ? sa :
                      (op[2:0] == 3'd1 || op[2:0] == 3'd4) ? (sa ^ sb) : 1'b0;
            state_d = op[2] ? S_DIV : S_MUL;
            acc_d   = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd_d  = op[2] ? mag_b : mag_a;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (flush_c) begin
          state_d = S_IDLE;
        end else if (&cnt_q) begin
          result_d = (mop_q == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (flush_c) begin
          state_d = S_IDLE;
        end else if (&cnt_q) begin
          result_d = neg_q ? -div_sel : div_sel;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      done_q   <= done_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always loaded at capture before being read.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    mop_q  <= mop_d;
    neg_q  <= neg_d;
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (XLEN=32); flush cases run when ALU_MDU_FLUSH_EN is defined.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero;
  logic [31:0] result;
`ifdef ALU_MDU_FLUSH_EN
  logic        flush;
`endif

  int errors = 0;
  int checks = 0;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef ALU_MDU_FLUSH_EN
    .flush  (flush),
`endif
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request at the current cycle and waits (bounded) for done.
  task automatic run_op(input string tag, input logic [4:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    int busy_cnt;
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef ALU_MDU_FLUSH_EN
    flush = 1'b0;
`endif
    #22;
    check("reset result", result, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Base group, back-to-back.
    run_op("add",    5'd0,  32'd7,          32'hFFFF_FFF9, 1, 32'd0);
    run_op("sub",    5'd1,  32'd5,          32'd7,         1, 32'hFFFF_FFFE);
    run_op("sra",    5'd7,  32'h8000_0000,  32'h24,        1, 32'hF800_0000);
    run_op("srl",    5'd6,  32'h8000_0000,  32'h24,        1, 32'h0800_0000);
    run_op("sll",    5'd5,  32'h0000_0003,  32'h1F,        1, 32'h8000_0000);
    run_op("sltu",   5'd9,  32'd1,          32'hFFFF_FFFF, 1, 32'd1);
    run_op("slt",    5'd8,  32'd1,          32'hFFFF_FFFF, 1, 32'd0);
    run_op("xor",    5'd2,  32'hF0F0_1234,  32'h0FF0_FFFF, 1, 32'hFF00_EDCB);
    run_op("pass12", 5'd12, 32'h1234_5678,  32'd9,         1, 32'h1234_5678);
    run_op("pass28", 5'd28, 32'hCAFE_0001,  32'd9,         1, 32'hCAFE_0001);

    // Multiply group.
    run_op("mulh",   5'd17, 32'hFFFF_FFFE,  32'd3,         33, 32'hFFFF_FFFF);
    check("done single pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("done drops", {31'd0, done}, 32'd0);
    run_op("mul",    5'd16, 32'hFFFF_FFFE,  32'd3,         33, 32'hFFFF_FFFA);
    run_op("mulh2",  5'd17, 32'hFFFF_FFFE,  32'h8000_0000, 33, 32'h0000_0001);
    run_op("mulhsu", 5'd18, 32'hFFFF_FFFE,  32'h8000_0000, 33, 32'hFFFF_FFFF);
    run_op("mulhu2", 5'd19, 32'hFFFF_FFFE,  32'h8000_0000, 33, 32'h7FFF_FFFF);

    // Divide group and early-outs.
    run_op("div",    5'd20, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD);
    run_op("rem",    5'd22, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFF);
    run_op("divu",   5'd21, 32'hFFFF_FFF9,  32'd2,         33, 32'h7FFF_FFFC);
    run_op("remu",   5'd23, 32'hFFFF_FFF9,  32'd2,         33, 32'd1);
    run_op("divu0",  5'd21, 32'd1234,       32'd0,         1, 32'hFFFF_FFFF);
    run_op("rem0",   5'd22, 32'h0000_1234,  32'd0,         1, 32'h0000_1234);
    run_op("divovf", 5'd20, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("removf", 5'd22, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'd0);

    // Start while busy is ignored; a start in the done cycle is taken.
    start = 1'b1; op = 5'd19; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("mulhu busy-start latency", 32'(lat), 32'd33);
    check("mulhu busy-start result", result, 32'hFFFF_FFFE);
    run_op("add after done", 5'd0, 32'd40, 32'd2, 1, 32'd42);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 5'd20; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("div busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset done", {31'd0, done}, 32'd0);
    check("mid reset result", result, 32'd0);
    check("mid reset zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("no done after reset", 32'(done_seen), 32'd0);

`ifdef ALU_MDU_FLUSH_EN
    run_op("add before flush", 5'd0, 32'd2, 32'd3, 1, 32'd5);
    start = 1'b1; op = 5'd16; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd5);
    @(posedge clk); #1;
    run_op("add after flush", 5'd0, 32'd2, 32'd2, 1, 32'd4);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("no done after flush", 32'(done_seen), 32'd0);
    flush = 1'b1; start = 1'b1; op = 5'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush drops start", {31'd0, done}, 32'd0);
    check("flush drops start result", result, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised successor to the single-cycle RV32I ALU: registered result, start/done handshake.
- Adds an iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) alongside the base integer ops.
- Sits in the execute stage; the control unit stalls the datapath while busy is high.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where busy=0.
- op  in  5  operation code (encoding under Behaviour).
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- busy  out  1  high while a multi-cycle operation is in flight.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  XLEN  registered result; holds until the next done.
- zero  out  1  registered, (result == 0).

Behaviour:
- Reset (asynchronous): result=0, zero=1, done=0, busy=0, state=IDLE. Any in-flight operation is discarded and produces no done.
- Op encoding, base group (single-cycle):
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is b[SHW-1:0].
  - 8 SLT (signed), 9 SLTU (unsigned); the result is zero-extended 1 or 0.
  - 10-15 and 24-31 pass A through.
- Op encoding, M group (multi-cycle): 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- States: IDLE, MUL, DIV.
- Base or pass-through op with start in IDLE:
  - result, zero and done=1 are registered at the next edge; latency 1.
  - busy stays 0 and the FSM stays in IDLE.
- M op with start in IDLE:
  - At the next edge, capture the operands as sign/magnitude per op; go to MUL or DIV; busy=1; iteration counter = 0.
- MUL state:
  - Radix-2 shift-add on |a| x |b|, 2*XLEN-bit product, one bit per cycle, XLEN cycles.
  - Final sign correction: MULH negates when sign(a)^sign(b); MULHSU negates when sign(a); MUL and MULHU take no sign correction on the low half.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
- DIV state:
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign is sign(a)^sign(b); remainder sign is sign(a).
- Completion: on the edge ending iteration XLEN, result, zero and done=1 are registered, busy=0, and the FSM returns to IDLE. Total latency is XLEN+1 cycles from start (33 at XLEN=32).
- Early-out cases, latency 1, never entering MUL or DIV:
  - b=0, DIV/DIVU: result = all-ones.
  - b=0, REM/REMU: result = a.
  - DIV with a=100..0 and b=all-ones: result = a.
  - REM with a=100..0 and b=all-ones: result = 0.
- start while busy=1 is ignored; the operands and op in that cycle are not captured.
- start in the same cycle that done pulses (busy already 0 in that cycle) is accepted normally; back-to-back throughput for base ops is 1 per cycle.
- done is never high for two consecutive cycles for the same request. a and b need not be held after the accepting edge.

Optional Feature:
- Macro: ALU_MDU_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 in MUL or DIV: the FSM returns to IDLE at the next edge, busy=0, no done, and result is unchanged.
  - flush=1 in IDLE with start: start is dropped.
  - flush has priority over start and over completion in the same cycle.
- Not defined: there is no flush port; an operation can only be aborted by reset.

Test Plan:
- Base ops:
  - start, op=0 (ADD), a=7, b=-7 -> next cycle done=1, result=0, zero=1, busy=0.
  - op=7 (SRA), a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000 after 1 cycle.
  - op=9 (SLTU), a=1, b=0xFFFFFFFF -> result=1.
- MUL/MULH:
  - op=17 (MULH), a=-2, b=3 -> busy high for 32 cycles, done exactly 33 cycles after start, result=0xFFFFFFFF.
  - op=16 (MUL), same operands -> result=0xFFFFFFFA.
- DIV/REM:
  - op=20 (DIV), a=-7, b=2 -> result=0xFFFFFFFD (-3) after 33 cycles.
  - op=22 (REM), same operands -> result=0xFFFFFFFF (-1).
  - op=21 (DIVU), b=0 -> done after 1 cycle, result=0xFFFFFFFF.
  - op=20 (DIV), a=0x80000000, b=-1 -> done after 1 cycle, result=0x80000000.
- Start while busy:
  - start MULHU a=b=0xFFFFFFFF; pulse start op=0 (ADD) at cycle 5 -> ignored; done at cycle 33 with result=0xFFFFFFFE.
  - Then start ADD in the done cycle -> done next cycle.
- Reset mid-operation:
  - Assert reset at cycle 10 of a DIV -> busy=0, done=0, result=0, zero=1 immediately.
  - After release, no done appears.
- Flush (ALU_MDU_FLUSH_EN defined):
  - flush at cycle 3 of a MUL -> busy=0 next cycle, no done, result keeps its prior value.
  - A new ADD started one cycle later completes normally.
